list_eval: RTL and testbench
============================

# list_eval

Parametrised successor to the single-step evaluator core: walks a tagged cons structure in shared memory and evaluates either a literal or a primitive application `(op a b ...)` over a flat list of numbers. Sits between the sequencer that launches evaluations and the tagged-word memory, using a held request/ready read port. Adds explicit start/done control, NIL and primitive tags, list traversal, structured error codes and a loop watchdog.

## Interface
- `WORD_W`, 16: tagged word width; must satisfy `WORD_W >= 1+TAG_W+ADDR_W`.
- `ADDR_W`, 12: payload/address width.
- `TAG_W`, 3: tag field width.
- `MAX_READS`, 256: memory-read budget per evaluation (watchdog).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch evaluation of `root`; sampled only in Idle.
- `root` in WORD_W: expression word, latched on accepted start.
- `busy` out 1: high in every state except Idle.
- `done` out 1: one-cycle pulse; `result` or `err_code` valid.
- `result` out WORD_W: NUMBER-tagged result; held until next accepted start.
- `err` out 1: evaluation failed; level, cleared on next accepted start.
- `err_code` out 4: error cause, valid while `err`.
- `mem_req` out 1: read request, held until `mem_ready`.
- `mem_addr` out ADDR_W: read address, stable while `mem_req`.
- `mem_ready` in 1: read data valid this cycle.
- `mem_data` in WORD_W: read data.

## Operation
- Word layout: bit WORD_W-1 mark (ignored), next TAG_W bits tag, low ADDR_W bits payload.
- Tags: NUMBER=0, CONS=1, NIL=2, PRIM=3; others invalid. Cons at A: car at A, cdr at A+1 (mod 2^ADDR_W).
- PRIM payload ops: 0 ADD (identity 0), 1 SUB, 2 AND (identity all-ones), 3 OR (identity 0); other values → E_OP.
- SUB: first argument loads acc, later ones subtract; one argument → negation; zero arguments → E_ARITY.
- Arithmetic on ADDR_W bits, wraps silently; result = {mark 0, NUMBER, acc}.
- States:
  - Idle: on `start`, latch root; clear acc, count, reads, err → Dispatch.
  - Dispatch: NUMBER → result=root, Done; CONS A → read A, cont=Head; else E_ROOT.
  - Read: assert `mem_req`/`mem_addr`; on `mem_ready` capture `mem_data` → cont.
  - Head: NUMBER → result=car, Done; PRIM → latch op, read A+1, cont=Link; else E_HEAD.
  - Link: NIL → finish (arity check, SUB negation) → Done; CONS B → cell=B, read B, cont=Arg; else E_LINK.
  - Arg: NUMBER → fold into acc, count++, read cell+1, cont=Link; else E_ARG.
  - Done: `done`=1 → Idle. Error: latch `err_code`, `err`=1, `done`=1 → Idle.
- Error codes: E_ROOT=1, E_HEAD=2, E_OP=3, E_LINK=4, E_ARG=5, E_ARITY=6, E_LOOP=7.
- Watchdog: issuing a read when `reads == MAX_READS` → E_LOOP instead (catches cyclic cdr chains).
- `start` while busy: ignored. `mem_ready` outside Read: ignored.

## Timing
- Reset values: `busy`,`done`,`err`,`mem_req`=0; `result`,`err_code`,`mem_addr`=0; state Idle.
- `rst` mid-operation: Idle next cycle, `mem_req` drops same edge; accumulator, counters cleared.
- All outputs registered or decoded from state register; no combinational path from `mem_ready` to `mem_req`.
- Start sampled at edge E0 → Dispatch cycle 1; each read costs 1 Read cycle + wait cycles + 1 continuation cycle.
- Zero-wait memory (`mem_ready` in first Read cycle): `done` in cycle 2+2R, R = reads.
- NUMBER root: `done` in cycle 2, no `mem_req`.
- `result` and `err` update in the same cycle `done` rises.

## Structure
- Package `eval_pkg`: `tag_t`, op enum, `err_t` codes, field-extract functions (`tag_of`, `payload_of`, `mk_number`), state enum.
- One combinational sub-module `prim_alu` (op, acc, arg, first → next acc); FSM, read port and watchdog stay in `list_eval`.

## Test plan
- Root 0x0007 (NUMBER 7) → `done` cycle 2, `result`=0x0007, `mem_req` never high.
- Root 0x1004; mem[4]=0x3000, [5]=0x1010, [0x10]=0x0002, [0x11]=0x1012, [0x12]=0x0003, [0x13]=0x2000; zero-wait → `result`=0x0005, `done` cycle 14.
- Same image, mem[4]=0x3001, 3 random wait cycles per read → `result`=0x0FFF (2−3 mod 4096), `mem_addr` stable while `mem_req`.
- mem[4]=0x3001, mem[5]=0x2000 → `err`=1, `err_code`=6; mem[0x12]=0x1020 → `err_code`=5.
- mem[0x13]=0x1010 (cycle), MAX_READS=16 → `err_code`=7 after exactly 16 reads.
- `rst` asserted during a held `mem_req` → `mem_req`=0 next cycle, `busy`=0; new `start` evaluates correctly.

Source files
------------

// File: rtl/eval_pkg.sv
// eval_pkg: shared types and tagged-word field helpers for the list evaluator
package eval_pkg;
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] wbus_t;
    typedef enum logic [7:0] {T_NUMBER = 8'd0, T_CONS = 8'd1, T_NIL = 8'd2, T_PRIM = 8'd3} tag_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;
    typedef enum logic [3:0] {
        E_NONE = 4'd0, E_ROOT = 4'd1, E_HEAD = 4'd2, E_OP = 4'd3,
        E_LINK = 4'd4, E_ARG = 4'd5, E_ARITY = 4'd6, E_LOOP = 4'd7
    } err_t;
    typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_READ, S_HEAD, S_LINK, S_ARG, S_DONE, S_ERR} state_t;

    function automatic wbus_t field_mask(input int w);
        return ~(~wbus_t'(0) << w);
    endfunction

    function automatic wbus_t tag_of(input wbus_t w, input int aw, input int tw);
        return (w >> aw) & field_mask(tw);
    endfunction

    function automatic wbus_t payload_of(input wbus_t w, input int aw);
        return w & field_mask(aw);
    endfunction

    function automatic wbus_t mk_number(input wbus_t p, input int aw);
        return (wbus_t'(T_NUMBER) << aw) | payload_of(p, aw);
    endfunction
endpackage

// File: rtl/list_eval_prim_alu.sv
// prim_alu: folds one argument into the primitive accumulator
module prim_alu
    import eval_pkg::*;
#(
    parameter int W = 12
) (
    input  op_t          i_op,
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_arg,
    input  logic         i_first,
    output logic [W-1:0] o_acc
);
    always_comb begin
        o_acc = i_first ? i_arg :
                i_op == OP_ADD ? i_acc + i_arg :
                i_op == OP_SUB ? i_acc - i_arg :
                i_op == OP_AND ? i_acc & i_arg : i_acc | i_arg;
    end
endmodule

// File: rtl/list_eval.sv
// list_eval: walks a tagged cons list in memory and evaluates a literal or primitive application
module list_eval
    import eval_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int TAG_W     = 3,
    parameter int MAX_READS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] root,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              err,
    output logic [3:0]        err_code,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_data
);
    localparam int RW = $clog2(MAX_READS + 1);

    state_t            r_state, r_cont, w_next, w_cont;
    logic [WORD_W-1:0] r_data, r_result, w_res;
    logic [ADDR_W-1:0] r_addr, r_acc, w_rd_addr, w_pay, w_fin, w_alu;
    logic [7:0]        w_tag;
    logic [RW-1:0]     r_reads, r_cnt;
    op_t               r_op;
    logic              r_err, w_rd, w_fail;
    err_t              r_code, w_code;

    // r_data holds the word under inspection: the root in Dispatch, the last read word afterwards
    assign w_tag = 8'(tag_of(MAX_W'(r_data), ADDR_W, TAG_W));
    assign w_pay = ADDR_W'(payload_of(MAX_W'(r_data), ADDR_W));
    assign w_fin = (r_op == OP_AND && r_cnt == '0) ? '1 :
                   (r_op == OP_SUB && r_cnt == RW'(1)) ? -r_acc : r_acc;
    assign w_res = WORD_W'(mk_number(MAX_W'(r_state == S_LINK ? w_fin : w_pay), ADDR_W));

    prim_alu #(.W(ADDR_W)) u_alu (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_arg  (w_pay),
        .i_first(r_cnt == '0),
        .o_acc  (w_alu)
    );

    always_comb begin
        w_next    = r_state;
        w_cont    = r_cont;
        w_rd      = 1'b0;
        w_rd_addr = r_addr;
        w_fail    = 1'b0;
        w_code    = E_NONE;
        case (r_state)
            S_IDLE: w_next = start ? S_DISPATCH : S_IDLE;
            S_DISPATCH:
                if (w_tag == T_NUMBER) w_next = S_DONE;
                else if (w_tag == T_CONS) begin
                    w_rd      = 1'b1;
                    w_rd_addr = w_pay;
                    w_cont    = S_HEAD;
                end else begin
                    w_fail = 1'b1;
                    w_code = E_ROOT;
                end
            S_READ: w_next = mem_ready ? r_cont : S_READ;
            S_HEAD:
                if (w_tag == T_NUMBER) w_next = S_DONE;
                else if (w_tag == T_PRIM && w_pay <= ADDR_W'(OP_OR)) begin
                    w_rd      = 1'b1;
                    w_rd_addr = r_addr + 1'b1;
                    w_cont    = S_LINK;
                end else begin
                    w_fail = 1'b1;
                    w_code = w_tag == T_PRIM ? E_OP : E_HEAD;
                end
            S_LINK:
                if (w_tag == T_NIL) begin
                    w_fail = r_op == OP_SUB && r_cnt == '0;
                    w_code = w_fail ? E_ARITY : E_NONE;
                    w_next = S_DONE;
                end else if (w_tag == T_CONS) begin
                    w_rd      = 1'b1;
                    w_rd_addr = w_pay;
                    w_cont    = S_ARG;
                end else begin
                    w_fail = 1'b1;
                    w_code = E_LINK;
                end
            S_ARG:
                if (w_tag == T_NUMBER) begin
                    w_rd      = 1'b1;
                    w_rd_addr = r_addr + 1'b1;
                    w_cont    = S_LINK;
                end else begin
                    w_fail = 1'b1;
                    w_code = E_ARG;
                end
            default: w_next = S_IDLE;
        endcase
        // a cyclic cdr chain runs the read budget dry before it can terminate
        if (w_rd && r_reads == RW'(MAX_READS)) begin
            w_fail = 1'b1;
            w_code = E_LOOP;
        end
        w_next = w_fail ? S_ERR : w_rd ? S_READ : w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cont   <= S_IDLE;
            r_data   <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_reads  <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_err    <= 1'b0;
            r_code   <= E_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_data  <= root;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_reads <= '0;
                r_err   <= 1'b0;
                r_code  <= E_NONE;
            end
            if (w_rd && !w_fail) begin
                r_addr  <= w_rd_addr;
                r_cont  <= w_cont;
                r_reads <= r_reads + RW'(1);
            end
            if (r_state == S_READ && mem_ready) r_data <= mem_data;
            if (r_state == S_HEAD && w_tag == T_PRIM) r_op <= op_t'(w_pay[1:0]);
            if (r_state == S_ARG && w_tag == T_NUMBER) begin
                r_acc <= w_alu;
                r_cnt <= r_cnt + RW'(1);
            end
            if (w_next == S_DONE) r_result <= w_res;
            if (w_next == S_ERR) begin
                r_err  <= 1'b1;
                r_code <= w_code;
            end
        end
    end

    assign busy     = r_state != S_IDLE;
    assign done     = r_state == S_DONE || r_state == S_ERR;
    assign mem_req  = r_state == S_READ;
    assign mem_addr = r_addr;
    assign result   = r_result;
    assign err      = r_err;
    assign err_code = r_code;
endmodule

// File: tb/tb_list_eval.sv
// tb_list_eval: table-driven scoreboard bench for list_eval with a wait-state memory model
module tb_list_eval;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mem_ready = 1'b0;
    logic        busy, done, err, mem_req;
    logic [15:0] root = '0, mem_data = '0, result;
    logic [3:0]  err_code;
    logic [11:0] mem_addr, addr_prev = '0;
    logic [15:0] mem [0:4095];
    int          tests = 0, fails = 0, reads = 0, stab_err = 0;
    int          wait_cnt = 0, wait_tgt = 0, fixed_wait = 0;
    bit          noise = 1'b0, req_prev = 1'b0;

    localparam logic [11:0] NA = 12'h100;

    typedef struct {
        string       name;
        logic [15:0] root;
        logic [11:0] pa0;
        logic [15:0] pd0;
        logic [11:0] pa1;
        logic [15:0] pd1;
        bit          rnd;
        bit          err;
        logic [3:0]  code;
        logic [15:0] res;
        int          cyc;
        int          nrd;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        bit          err;
        logic [3:0]  code;
        int          cyc;
        int          nrd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    list_eval #(.WORD_W(16), .ADDR_W(12), .TAG_W(3), .MAX_READS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .root(root), .busy(busy), .done(done),
        .result(result), .err(err), .err_code(err_code), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // memory responder: waits wait_tgt Read cycles, then returns data; optional junk ready outside reads
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_prev && mem_addr !== addr_prev) stab_err++;
            if (wait_cnt >= wait_tgt) begin
                mem_ready = 1'b1;
                mem_data  = mem[mem_addr];
                reads++;
                wait_cnt  = 0;
                wait_tgt  = noise ? int'($urandom_range(0, 3)) : fixed_wait;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = noise;
            mem_data  = 16'h1FFF;
            wait_cnt  = 0;
        end
        req_prev  = mem_req;
        addr_prev = mem_addr;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [15:0] r,
                                input logic [11:0] a0, input logic [15:0] d0,
                                input logic [11:0] a1, input logic [15:0] d1,
                                input bit rnd, input bit e, input logic [3:0] c,
                                input logic [15:0] res, input int cyc, input int nrd);
        vec_t v;
        v.name = n; v.root = r; v.pa0 = a0; v.pd0 = d0; v.pa1 = a1; v.pd1 = d1;
        v.rnd = rnd; v.err = e; v.code = c; v.res = res; v.cyc = cyc; v.nrd = nrd;
        return v;
    endfunction

    task automatic load_mem(input vec_t v);
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        mem[12'h004] = 16'h3000;
        mem[12'h005] = 16'h1010;
        mem[12'h010] = 16'h0002;
        mem[12'h011] = 16'h1012;
        mem[12'h012] = 16'h0003;
        mem[12'h013] = 16'h2000;
        mem[v.pa0] = v.pd0;
        mem[v.pa1] = v.pd1;
    endtask

    task automatic run(input vec_t v, input bit poke);
        int   cyc;
        bit   got;
        exp_t e;
        load_mem(v);
        noise    = v.rnd;
        wait_tgt = v.rnd ? int'($urandom_range(0, 3)) : fixed_wait;
        reads    = 0;
        sb.push_back('{v.res, v.err, v.code, v.cyc, v.nrd});
        @(negedge clk);
        start = 1'b1;
        root  = v.root;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) begin
                start = 1'b1;
                root  = 16'h0007;
            end
            if (poke && cyc == 4) start = 1'b0;
            got = done;
        end
        e = sb.pop_front();
        chk({v.name, "_done"}, 32'(got), 32'd1);
        if (got) begin
            chk({v.name, "_err"}, 32'(err), 32'(e.err));
            if (e.err) chk({v.name, "_code"}, 32'(err_code), 32'(e.code));
            else chk({v.name, "_result"}, 32'(result), 32'(e.res));
            if (e.cyc >= 0) chk({v.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            chk({v.name, "_reads"}, 32'(reads), 32'(e.nrd));
        end
    endtask

    initial begin
        int n;
        vecs.push_back(mk("num",       16'h0007, NA, 16'h0000, NA, 16'h0000, 0, 0, 4'd0, 16'h0007, 2, 0));
        vecs.push_back(mk("add",       16'h1004, NA, 16'h0000, NA, 16'h0000, 0, 0, 4'd0, 16'h0005, 14, 6));
        vecs.push_back(mk("sub_wait",  16'h1004, 12'h004, 16'h3001, NA, 16'h0000, 1, 0, 4'd0, 16'h0FFF, -1, 6));
        vecs.push_back(mk("arity",     16'h1004, 12'h004, 16'h3001, 12'h005, 16'h2000, 0, 1, 4'd6, 16'h0000, 6, 2));
        vecs.push_back(mk("bad_arg",   16'h1004, 12'h012, 16'h1020, NA, 16'h0000, 0, 1, 4'd5, 16'h0000, 12, 5));
        vecs.push_back(mk("loop",      16'h1004, 12'h013, 16'h1010, NA, 16'h0000, 0, 1, 4'd7, 16'h0000, 34, 16));
        vecs.push_back(mk("head_num",  16'h1004, 12'h004, 16'h0009, NA, 16'h0000, 0, 0, 4'd0, 16'h0009, 4, 1));
        vecs.push_back(mk("root_nil",  16'h2000, NA, 16'h0000, NA, 16'h0000, 0, 1, 4'd1, 16'h0000, 2, 0));
        vecs.push_back(mk("root_bad",  16'h5000, NA, 16'h0000, NA, 16'h0000, 0, 1, 4'd1, 16'h0000, 2, 0));
        vecs.push_back(mk("head_cons", 16'h1004, 12'h004, 16'h1000, NA, 16'h0000, 0, 1, 4'd2, 16'h0000, 4, 1));
        vecs.push_back(mk("bad_op",    16'h1004, 12'h004, 16'h3004, NA, 16'h0000, 0, 1, 4'd3, 16'h0000, 4, 1));
        vecs.push_back(mk("link_num",  16'h1004, 12'h005, 16'h0001, NA, 16'h0000, 0, 1, 4'd4, 16'h0000, 6, 2));
        vecs.push_back(mk("and",       16'h1004, 12'h004, 16'h3002, NA, 16'h0000, 0, 0, 4'd0, 16'h0002, 14, 6));
        vecs.push_back(mk("or",        16'h1004, 12'h004, 16'h3003, NA, 16'h0000, 0, 0, 4'd0, 16'h0003, 14, 6));
        vecs.push_back(mk("and_empty", 16'h1004, 12'h004, 16'h3002, 12'h005, 16'h2000, 0, 0, 4'd0, 16'h0FFF, 6, 2));
        vecs.push_back(mk("neg",       16'h1004, 12'h004, 16'h3001, 12'h011, 16'h2000, 0, 0, 4'd0, 16'h0FFE, 10, 4));
        vecs.push_back(mk("wrap_wait", 16'h1004, 12'h010, 16'h0FFF, NA, 16'h0000, 1, 0, 4'd0, 16'h0002, -1, 6));
        vecs.push_back(mk("loop_wait", 16'h1004, 12'h013, 16'h1010, NA, 16'h0000, 1, 1, 4'd7, 16'h0000, -1, 16));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_done",     32'(done),     32'd0);
        chk("reset_err",      32'(err),      32'd0);
        chk("reset_mem_req",  32'(mem_req),  32'd0);
        chk("reset_result",   32'(result),   32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i], i == 1);

        // reset while a read is held pending, then a clean re-run
        fixed_wait = 50;
        noise      = 1'b0;
        load_mem(vecs[1]);
        wait_tgt = fixed_wait;
        @(negedge clk);
        start = 1'b1;
        root  = 16'h1004;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_req_seen", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'd0);
        chk("rst_busy",     32'(busy),    32'd0);
        chk("rst_done",     32'(done),    32'd0);
        chk("rst_result",   32'(result),  32'd0);
        @(negedge clk);
        rst        = 1'b0;
        fixed_wait = 0;
        run(vecs[1], 1'b0);

        chk("addr_stable", 32'(stab_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
